// File: rtl/cram_axi_rd_slave.sv
// AXI4 read-only responder for the code RAM with a loader write port.
// Optional SLVERR reporting for out-of-range addresses is enabled by `define CRAM_SLVERR_EN.
module cram_axi_rd_slave #(
   parameter int WORDS    = 8192,
   parameter int AR_DEPTH = 4,
   parameter int ID_W     = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [ID_W-1:0]           s_arid,
   input  logic [31:0]               s_araddr,
   input  logic [7:0]                s_arlen,
   input  logic [2:0]                s_arsize,
   input  logic [1:0]                s_arburst,
   input  logic                      s_arvalid,
   output logic                      s_arready,
   output logic [ID_W-1:0]           s_rid,
   output logic [31:0]               s_rdata,
   output logic [1:0]                s_rresp,
   output logic                      s_rlast,
   output logic                      s_rvalid,
   input  logic                      s_rready,
   input  logic                      ld_we,
   input  logic [$clog2(WORDS)-1:0]  ld_addr,
   input  logic [31:0]               ld_data
);
   localparam int IW = $clog2(WORDS);
   localparam int AW = $clog2(AR_DEPTH);

   typedef enum logic {IDLE, BURST} state_t;

   // AR request queue
   logic [ID_W-1:0] q_id    [AR_DEPTH];
   logic [IW-1:0]   q_addr  [AR_DEPTH];
   logic [7:0]      q_len   [AR_DEPTH];
   logic [1:0]      q_burst [AR_DEPTH];
   logic            q_err   [AR_DEPTH];
   logic [AW-1:0]   q_wr_reg, q_rd_reg;
   logic [AW:0]     q_cnt_reg;
   logic            q_full, q_empty, q_pop, ar_push, ar_err;

   assign q_full    = (q_cnt_reg == (AW+1)'(AR_DEPTH));
   assign q_empty   = (q_cnt_reg == '0);
   assign s_arready = !rst && !q_full;
   assign ar_push   = s_arvalid && s_arready;

`ifdef CRAM_SLVERR_EN
   assign ar_err = |s_araddr[31:IW+2];
`else
   assign ar_err = 1'b0;
`endif

   // arsize is always treated as 4-byte, byte lane bits are don't-care
   logic unused_bits;
   assign unused_bits = &{1'b0, s_arsize, s_araddr[1:0], s_araddr[31:IW+2]};

   always_ff @(posedge clk) begin
      if (ar_push) begin
         q_id[q_wr_reg]    <= s_arid;
         q_addr[q_wr_reg]  <= s_araddr[IW+1:2];
         q_len[q_wr_reg]   <= s_arlen;
         q_burst[q_wr_reg] <= s_arburst;
         q_err[q_wr_reg]   <= ar_err;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_wr_reg  <= '0;
         q_rd_reg  <= '0;
         q_cnt_reg <= '0;
      end else begin
         if (ar_push) q_wr_reg <= q_wr_reg + AW'(1);
         if (q_pop)   q_rd_reg <= q_rd_reg + AW'(1);
         q_cnt_reg <= q_cnt_reg + (AW+1)'(ar_push) - (AW+1)'(q_pop);
      end
   end

   // Burst walker
   state_t          state_reg, state_next;
   logic [IW-1:0]   b_addr_reg, b_addr_next;
   logic [ID_W-1:0] b_id_reg, b_id_next;
   logic [7:0]      b_len_reg, b_len_next;
   logic [7:0]      b_cnt_reg, b_cnt_next;
   logic [1:0]      b_burst_reg, b_burst_next;
   logic            b_err_reg, b_err_next;

   logic            cur_valid, cur_err, cur_last, cur_fixed, issue, adv_err;
   logic [IW-1:0]   cur_addr, adv_addr;
   logic [ID_W-1:0] cur_id;
   logic [7:0]      cur_len, cur_cnt;
   logic [1:0]      cur_burst;

   logic            rq_valid_reg, rq_last_reg, rq_err_reg;
   logic [ID_W-1:0] rq_id_reg;
   logic            sk_valid_reg, sk_last_reg, sk_err_reg;
   logic [ID_W-1:0] sk_id_reg;
   logic [31:0]     sk_data_reg, ram_q, rq_data;
   logic            credit, r_pop, pop_rq, pop_sk;

   // In IDLE the queue head is the current beat so the first read needs no extra cycle
   always_comb begin
      if (state_reg == BURST) begin
         cur_valid = 1'b1;
         cur_addr  = b_addr_reg;
         cur_id    = b_id_reg;
         cur_len   = b_len_reg;
         cur_cnt   = b_cnt_reg;
         cur_burst = b_burst_reg;
         cur_err   = b_err_reg;
      end else begin
         cur_valid = !q_empty;
         cur_addr  = q_addr[q_rd_reg];
         cur_id    = q_id[q_rd_reg];
         cur_len   = q_len[q_rd_reg];
         cur_cnt   = 8'd0;
         cur_burst = q_burst[q_rd_reg];
         cur_err   = q_err[q_rd_reg];
      end
   end

   assign credit    = !(rq_valid_reg && sk_valid_reg);
   assign issue     = cur_valid && credit;
   assign cur_last  = (cur_cnt == cur_len);
   assign cur_fixed = (cur_burst == 2'b00);
   assign adv_addr  = cur_fixed ? cur_addr : cur_addr + IW'(1);

`ifdef CRAM_SLVERR_EN
   assign adv_err = cur_err | (!cur_fixed && (&cur_addr));
`else
   assign adv_err = cur_err;
`endif

   always_comb begin
      state_next   = state_reg;
      b_addr_next  = b_addr_reg;
      b_id_next    = b_id_reg;
      b_len_next   = b_len_reg;
      b_cnt_next   = b_cnt_reg;
      b_burst_next = b_burst_reg;
      b_err_next   = b_err_reg;
      q_pop        = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!q_empty) begin
               q_pop        = 1'b1;
               b_addr_next  = q_addr[q_rd_reg];
               b_id_next    = q_id[q_rd_reg];
               b_len_next   = q_len[q_rd_reg];
               b_burst_next = q_burst[q_rd_reg];
               b_err_next   = q_err[q_rd_reg];
               b_cnt_next   = 8'd0;
               state_next   = BURST;
               if (issue) begin
                  if (cur_last) begin
                     state_next = IDLE;
                  end else begin
                     b_cnt_next  = 8'd1;
                     b_addr_next = adv_addr;
                     b_err_next  = adv_err;
                  end
               end
            end
         end
         BURST: begin
            if (issue) begin
               if (!cur_last) begin
                  b_cnt_next  = b_cnt_reg + 8'd1;
                  b_addr_next = adv_addr;
                  b_err_next  = adv_err;
               end else if (!q_empty) begin
                  q_pop        = 1'b1;
                  b_addr_next  = q_addr[q_rd_reg];
                  b_id_next    = q_id[q_rd_reg];
                  b_len_next   = q_len[q_rd_reg];
                  b_burst_next = q_burst[q_rd_reg];
                  b_err_next   = q_err[q_rd_reg];
                  b_cnt_next   = 8'd0;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         b_addr_reg  <= '0;
         b_id_reg    <= '0;
         b_len_reg   <= '0;
         b_cnt_reg   <= '0;
         b_burst_reg <= '0;
         b_err_reg   <= 1'b0;
      end else begin
         state_reg   <= state_next;
         b_addr_reg  <= b_addr_next;
         b_id_reg    <= b_id_next;
         b_len_reg   <= b_len_next;
         b_cnt_reg   <= b_cnt_next;
         b_burst_reg <= b_burst_next;
         b_err_reg   <= b_err_next;
      end
   end

   // Code RAM, read-first so a same-cycle load returns the old word
   logic [31:0] mem [WORDS];

   always_ff @(posedge clk) begin
      if (ld_we) mem[ld_addr] <= ld_data;
      if (issue) ram_q <= mem[cur_addr];
   end

   // The RAM output register is one buffer slot; the skid register is the second
   assign rq_data = rq_err_reg ? 32'd0 : ram_q;
   assign r_pop   = s_rvalid && s_rready;
   assign pop_sk  = r_pop && sk_valid_reg;
   assign pop_rq  = r_pop && !sk_valid_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rq_valid_reg <= 1'b0;
         rq_id_reg    <= '0;
         rq_last_reg  <= 1'b0;
         rq_err_reg   <= 1'b0;
         sk_valid_reg <= 1'b0;
         sk_id_reg    <= '0;
         sk_data_reg  <= '0;
         sk_last_reg  <= 1'b0;
         sk_err_reg   <= 1'b0;
      end else begin
         if (issue) begin
            rq_valid_reg <= 1'b1;
            rq_id_reg    <= cur_id;
            rq_last_reg  <= cur_last;
            rq_err_reg   <= cur_err;
         end else if (pop_rq) begin
            rq_valid_reg <= 1'b0;
         end
         if (issue && rq_valid_reg && !pop_rq) begin
            sk_valid_reg <= 1'b1;
            sk_id_reg    <= rq_id_reg;
            sk_data_reg  <= rq_data;
            sk_last_reg  <= rq_last_reg;
            sk_err_reg   <= rq_err_reg;
         end else if (pop_sk) begin
            sk_valid_reg <= 1'b0;
         end
      end
   end

   assign s_rvalid = sk_valid_reg | rq_valid_reg;

   always_comb begin
      s_rid   = '0;
      s_rdata = '0;
      s_rresp = 2'b00;
      s_rlast = 1'b0;
      if (sk_valid_reg) begin
         s_rid   = sk_id_reg;
         s_rdata = sk_data_reg;
         s_rresp = sk_err_reg ? 2'b10 : 2'b00;
         s_rlast = sk_last_reg;
      end else if (rq_valid_reg) begin
         s_rid   = rq_id_reg;
         s_rdata = rq_data;
         s_rresp = rq_err_reg ? 2'b10 : 2'b00;
         s_rlast = rq_last_reg;
      end
   end

endmodule

// File: tb/tb_cram_axi_rd_slave.sv
// Self-checking bench for cram_axi_rd_slave: directed scenarios plus randomized bursts
// checked against a beat-list reference model built from a shadow copy of the RAM.
module tb_cram_axi_rd_slave;
   localparam int WORDS    = 256;
   localparam int AR_DEPTH = 4;
   localparam int ID_W     = 4;
   localparam int IW       = $clog2(WORDS);

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [ID_W-1:0] s_arid = '0;
   logic [31:0]     s_araddr = '0;
   logic [7:0]      s_arlen = '0;
   logic [2:0]      s_arsize = 3'd2;
   logic [1:0]      s_arburst = 2'd1;
   logic            s_arvalid = 1'b0;
   logic            s_arready;
   logic [ID_W-1:0] s_rid;
   logic [31:0]     s_rdata;
   logic [1:0]      s_rresp;
   logic            s_rlast;
   logic            s_rvalid;
   logic            s_rready;
   logic            ld_we = 1'b0;
   logic [IW-1:0]   ld_addr = '0;
   logic [31:0]     ld_data = '0;

   cram_axi_rd_slave #(.WORDS(WORDS), .AR_DEPTH(AR_DEPTH), .ID_W(ID_W)) dut (
      .clk(clk), .rst(rst),
      .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
      .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
      .s_rvalid(s_rvalid), .s_rready(s_rready),
      .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [31:0]     data;
      logic            last;
      logic [1:0]      resp;
   } beat_t;

   beat_t       exp_q[$];
   logic [31:0] model_mem [WORDS];
   int          n_checks = 0;
   int          n_pass = 0;
   bit          model_en = 1'b0;
   bit          rdy_rand = 1'b0;
   logic        rdy_force = 1'b1;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Expected beat list for one request, straight from the addressing rules
   function automatic void model_ar(input logic [ID_W-1:0] id, input logic [31:0] addr,
                                    input logic [7:0] len, input logic [1:0] burst);
      int w0;
      w0 = int'(addr[IW+1:2]);
      for (int i = 0; i <= int'(len); i++) begin
         int    w;
         bit    err;
         beat_t b;
         err = 1'b0;
         w = (burst == 2'd0) ? w0 : (w0 + i) % WORDS;
`ifdef CRAM_SLVERR_EN
         err = (addr[31:IW+2] != '0) || (burst != 2'd0 && (w0 + i) >= WORDS);
`endif
         b.id   = id;
         b.data = err ? 32'd0 : model_mem[w];
         b.last = (i == int'(len));
         b.resp = err ? 2'b10 : 2'b00;
         exp_q.push_back(b);
      end
   endfunction

   // Observe both channels away from the active edge
   always @(negedge clk) begin
      if (!rst) begin
         if (s_rvalid) begin
            if (exp_q.size() == 0) begin
               check_value("stray_beat", 32'(exp_q.size()), 32'd1);
            end else begin
               check_value("rid",   32'(s_rid),   32'(exp_q[0].id));
               check_value("rdata", s_rdata,      exp_q[0].data);
               check_value("rlast", 32'(s_rlast), 32'(exp_q[0].last));
               check_value("rresp", 32'(s_rresp), 32'(exp_q[0].resp));
               if (s_rready) void'(exp_q.pop_front());
            end
         end
         if (model_en && s_arvalid && s_arready) begin
            model_ar(s_arid, s_araddr, s_arlen, s_arburst);
            $display("AR id=%0d addr=0x%08h len=%0d burst=%0d", s_arid, s_araddr, s_arlen, s_arburst);
         end
      end
   end

   initial begin
      s_rready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         s_rready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time %0t exceeds limit 500000", $time);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input int a, input logic [31:0] d);
      ld_we   = 1'b1;
      ld_addr = IW'(a);
      ld_data = d;
      model_mem[a] = d;
      step();
      ld_we = 1'b0;
   endtask

   task automatic send_ar(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size);
      int t;
      s_arid    = id;
      s_araddr  = addr;
      s_arlen   = len;
      s_arburst = burst;
      s_arsize  = size;
      s_arvalid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!s_arready && t < 200) begin
         t++;
         @(negedge clk);
      end
      check_value("ar_accept", 32'(s_arready), 32'd1);
      step();
   endtask

   task automatic wait_drain(input int limit);
      int t;
      t = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || s_rvalid) && t < limit) begin
         t++;
         @(negedge clk);
      end
      check_value("drain", 32'(exp_q.size()), 32'd0);
      step();
   endtask

   task automatic measure_run(output int run);
      int t;
      t = 0;
      run = 0;
      @(negedge clk);
      while (!s_rvalid && t < 20) begin
         t++;
         @(negedge clk);
      end
      while (s_rvalid && run < 300) begin
         run++;
         @(negedge clk);
      end
      step();
   endtask

   initial begin
      int run;
      logic [31:0] addr, upper;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_value("rst_arready", 32'(s_arready), 32'd0);
      check_value("rst_rvalid",  32'(s_rvalid),  32'd0);
      check_value("rst_rlast",   32'(s_rlast),   32'd0);
      check_value("rst_rresp",   32'(s_rresp),   32'd0);
      check_value("rst_rid",     32'(s_rid),     32'd0);
      check_value("rst_rdata",   s_rdata,        32'd0);
      step();
      rst = 1'b0;
      @(negedge clk);
      check_value("post_rst_arready", 32'(s_arready), 32'd1);
      step();

      for (int i = 0; i < WORDS; i++)
         load_word(i, (i < 8) ? 32'hA000_0000 + 32'(i) : $urandom);
      model_en = 1'b1;

      // single beat latency
      s_arid = 4'd3; s_araddr = 32'h8; s_arlen = 8'd0; s_arburst = 2'd1; s_arsize = 3'd2;
      s_arvalid = 1'b1;
      @(negedge clk);
      check_value("lat_arready", 32'(s_arready), 32'd1);
      step();
      s_arvalid = 1'b0;
      @(negedge clk);
      check_value("lat_t1_rvalid", 32'(s_rvalid), 32'd0);
      @(negedge clk);
      check_value("lat_t2_rvalid", 32'(s_rvalid), 32'd1);
      check_value("lat_t2_rdata",  s_rdata,        32'hA000_0002);
      check_value("lat_t2_rlast",  32'(s_rlast),   32'd1);
      step();
      wait_drain(50);

      // 8-beat INCR with no gaps
      send_ar(4'd4, 32'h0, 8'd7, 2'd1, 3'd2);
      s_arvalid = 1'b0;
      measure_run(run);
      check_value("incr_run", 32'(run), 32'd8);
      wait_drain(50);

      // back-to-back requests stream contiguously
      send_ar(4'd1, 32'h0, 8'd3, 2'd1, 3'd2);
      send_ar(4'd2, 32'h10, 8'd1, 2'd1, 3'd2);
      s_arvalid = 1'b0;
      measure_run(run);
      check_value("b2b_run", 32'(run), 32'd6);
      wait_drain(50);

      // rready 1-0-0-1 during a 4-beat burst
      send_ar(4'd5, 32'h0, 8'd3, 2'd1, 3'd2);
      s_arvalid = 1'b0;
      step();
      rdy_force = 1'b1;
      step();
      rdy_force = 1'b0;
      step();
      rdy_force = 1'b0;
      @(negedge clk);
      check_value("stall_rvalid", 32'(s_rvalid), 32'd1);
      check_value("stall_rdata",  s_rdata,        32'hA000_0001);
      step();
      rdy_force = 1'b1;
      wait_drain(50);

      // queue fills after 4 queued + 1 in the walker
      rdy_force = 1'b0;
      for (int k = 0; k < 5; k++)
         send_ar(ID_W'(k), 32'(k * 16), 8'd3, 2'd1, 3'd2);
      s_arid = 4'd13; s_araddr = 32'h40; s_arlen = 8'd0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_value("full_arready", 32'(s_arready), 32'd0);
         step();
      end
      s_arvalid = 1'b0;
      rdy_force = 1'b1;
      wait_drain(200);

      // FIXED burst with a same-cycle load to the word being read
      model_en = 1'b0;
      exp_q.push_back('{id: 4'd6, data: 32'hA000_0001, last: 1'b0, resp: 2'b00});
      exp_q.push_back('{id: 4'd6, data: 32'h0000_0055, last: 1'b0, resp: 2'b00});
      exp_q.push_back('{id: 4'd6, data: 32'h0000_0055, last: 1'b1, resp: 2'b00});
      send_ar(4'd6, 32'h4, 8'd2, 2'd0, 3'd2);
      s_arvalid = 1'b0;
      ld_we = 1'b1; ld_addr = IW'(1); ld_data = 32'h55;
      model_mem[1] = 32'h55;
      step();
      ld_we = 1'b0;
      wait_drain(50);
      model_en = 1'b1;

      // randomized traffic with random backpressure
      rdy_rand = 1'b1;
      for (int n = 0; n < 60; n++) begin
         upper = ($urandom_range(0, 3) == 0) ? $urandom : 32'd0;
         addr  = (upper << (IW + 2)) | (32'($urandom_range(0, WORDS - 1)) << 2) | 32'($urandom_range(0, 3));
         send_ar(ID_W'($urandom), addr,
                 ($urandom_range(0, 3) == 0) ? 8'($urandom_range(8, 20)) : 8'($urandom_range(0, 7)),
                 2'($urandom_range(0, 2)), 3'($urandom_range(0, 7)));
         s_arvalid = 1'b0;
         repeat ($urandom_range(0, 3)) step();
         if (n % 20 == 19) begin
            wait_drain(3000);
            for (int k = 0; k < 8; k++)
               load_word($urandom_range(0, WORDS - 1), $urandom);
         end
      end
      rdy_rand = 1'b0;
      rdy_force = 1'b1;
      wait_drain(3000);

      // reset in the middle of a stalled burst
      rdy_force = 1'b0;
      send_ar(4'd7, 32'h0, 8'd7, 2'd1, 3'd2);
      s_arvalid = 1'b0;
      repeat (3) step();
      rst = 1'b1;
      #1;
      check_value("midrst_rvalid",  32'(s_rvalid),  32'd0);
      check_value("midrst_arready", 32'(s_arready), 32'd0);
      exp_q.delete();
      repeat (2) step();
      rst = 1'b0;
      rdy_force = 1'b1;
      repeat (3) step();
      send_ar(4'd9, 32'h18, 8'd1, 2'd1, 3'd2);
      s_arvalid = 1'b0;
      wait_drain(50);

`ifdef CRAM_SLVERR_EN
      send_ar(4'd10, 32'h0010_0000, 8'd1, 2'd1, 3'd2);
      s_arvalid = 1'b0;
      wait_drain(50);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
